// File: rtl/xldr_spi_flash_fetch.sv
// ----------------------------------------------------------------------------
// xldr_spi_flash_fetch
//
// Streams a bitstream out of SPI flash with a plain READ (opcode + 24-bit
// address, mode 0). It packs the returned bytes into 32-bit words in loader
// FIFO entry format (data, n_bytes-1, last) and presents them on a valid/ready
// stream, so the loader can boot the FPGA without the host pushing data.
//
// Parameters
//   g_clk_div   SCLK half-period in clk_sys_i cycles (>= 1)
//   g_read_cmd  opcode sent ahead of the address
//
// Ports
//   clk_sys_i, rst_n_i         clock, asynchronous active-low reset
//   start_i, abort_i           1-cycle control pulses
//   base_addr_i, length_i      fetch window, sampled on an accepted start
//   busy_o, done_o             fetch in progress / normal completion pulse
//   spi_sclk_o, spi_ncs_o,
//   spi_mosi_o, spi_miso_i     SPI master pins
//   out_valid_o, out_ready_i,
//   out_data_o, out_nbytes_o,
//   out_last_o                 packed word stream
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | chip select high, waiting for start
// CMD    | shifting opcode + address out on MOSI
// DATA   | clocking data bytes in from MISO
// STALL  | assembly and output registers full; SCLK parked low
// FINISH | last byte in; finish SCLK, raise ncs, wait for last word to drain
// ----------------------------------------------------------------------------
module xldr_spi_flash_fetch #(
    parameter int          g_clk_div  = 2,
    parameter logic [7:0]  g_read_cmd = 8'h03
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [23:0] base_addr_i,
    input  logic [23:0] length_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_sclk_o,
    output logic        spi_ncs_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [1:0]  out_nbytes_o,
    output logic        out_last_o
);

    localparam logic [15:0] DIV_RELOAD = 16'(g_clk_div - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_STALL,
        ST_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] cmd_sr_q, cmd_sr_d;
    logic [23:0] len_q, len_d;
    logic [7:0]  byte_sr_q, byte_sr_d;
    logic [1:0]  byte_pos_q, byte_pos_d;
    logic [31:0] asm_data_q, asm_data_d;
    logic [1:0]  asm_nb_q, asm_nb_d;
    logic        asm_last_q, asm_last_d;
    logic        asm_full_q, asm_full_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_nb_q, out_nb_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;

    logic        tick;
    logic        xfer;
    logic        asm_blocked;
    logic [7:0]  new_byte;

    assign tick        = (div_cnt_q == 16'd0);
    // Assembly register moves to the output register whenever the latter is
    // empty or being emptied in the same cycle.
    assign xfer        = asm_full_q && (!out_valid_q || out_ready_i);
    assign asm_blocked = asm_full_q && !xfer;
    assign new_byte    = {byte_sr_q[6:0], spi_miso_i};

    always_comb begin
        state_d     = state_q;
        ncs_d       = ncs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        len_d       = len_q;
        byte_sr_d   = byte_sr_q;
        byte_pos_d  = byte_pos_q;
        asm_data_d  = asm_data_q;
        asm_nb_d    = asm_nb_q;
        asm_last_d  = asm_last_q;
        asm_full_d  = asm_full_q;
        out_data_d  = out_data_q;
        out_nb_d    = out_nb_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            out_data_d  = asm_data_q;
            out_nb_d    = asm_nb_q;
            out_last_d  = asm_last_q;
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (length_i == 24'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_CMD;
                        busy_d     = 1'b1;
                        ncs_d      = 1'b0;
                        sclk_d     = 1'b0;
                        mosi_d     = g_read_cmd[7];
                        cmd_sr_d   = {g_read_cmd[6:0], base_addr_i, 1'b0};
                        bit_cnt_d  = 5'd31;
                        div_cnt_d  = DIV_RELOAD;
                        len_d      = length_i;
                        byte_pos_d = 2'd0;
                    end
                end
            end

            ST_CMD: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end else begin
                    div_cnt_d = DIV_RELOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // The flash turns the bus around on this falling edge.
                        if (bit_cnt_q == 5'd0) begin
                            state_d   = ST_DATA;
                            mosi_d    = 1'b0;
                            bit_cnt_d = 5'd7;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 5'd1;
                            mosi_d    = cmd_sr_q[31];
                            cmd_sr_d  = {cmd_sr_q[30:0], 1'b0};
                        end
                    end
                end
            end

            ST_DATA: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end else if (sclk_q) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = DIV_RELOAD;
                end else if (asm_blocked) begin
                    // Only reachable at a word boundary: asm fills on the
                    // last byte of a word and drains before the next one ends.
                    state_d = ST_STALL;
                end else begin
                    sclk_d    = 1'b1;
                    div_cnt_d = DIV_RELOAD;
                    byte_sr_d = new_byte;
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else begin
                        bit_cnt_d  = 5'd7;
                        byte_pos_d = byte_pos_q + 2'd1;
                        len_d      = len_q - 24'd1;
                        case (byte_pos_q)
                            2'd0:    asm_data_d = {new_byte, 24'd0};
                            2'd1:    asm_data_d[23:16] = new_byte;
                            2'd2:    asm_data_d[15:8]  = new_byte;
                            default: asm_data_d[7:0]   = new_byte;
                        endcase
                        if (len_q == 24'd1 || byte_pos_q == 2'd3) begin
                            asm_full_d = 1'b1;
                            asm_nb_d   = byte_pos_q;
                            asm_last_d = (len_q == 24'd1);
                        end
                        if (len_q == 24'd1) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end

            ST_STALL: begin
                if (!asm_blocked) begin
                    state_d   = ST_DATA;
                    div_cnt_d = DIV_RELOAD;
                end
            end

            ST_FINISH: begin
                if (!ncs_q) begin
                    if (!tick) begin
                        div_cnt_d = div_cnt_q - 16'd1;
                    end else if (sclk_q) begin
                        sclk_d    = 1'b0;
                        div_cnt_d = DIV_RELOAD;
                    end else begin
                        ncs_d = 1'b1;
                    end
                end else if (!asm_full_q && !out_valid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d     = ST_IDLE;
            ncs_d       = 1'b1;
            sclk_d      = 1'b0;
            mosi_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            out_valid_d = 1'b0;
            asm_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ncs_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_cnt_q   <= 16'd0;
            bit_cnt_q   <= 5'd0;
            cmd_sr_q    <= 32'd0;
            len_q       <= 24'd0;
            byte_sr_q   <= 8'd0;
            byte_pos_q  <= 2'd0;
            asm_data_q  <= 32'd0;
            asm_nb_q    <= 2'd0;
            asm_last_q  <= 1'b0;
            asm_full_q  <= 1'b0;
            out_data_q  <= 32'd0;
            out_nb_q    <= 2'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ncs_q       <= ncs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            len_q       <= len_d;
            byte_sr_q   <= byte_sr_d;
            byte_pos_q  <= byte_pos_d;
            asm_data_q  <= asm_data_d;
            asm_nb_q    <= asm_nb_d;
            asm_last_q  <= asm_last_d;
            asm_full_q  <= asm_full_d;
            out_data_q  <= out_data_d;
            out_nb_q    <= out_nb_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_ncs_o    = ncs_q;
    assign spi_mosi_o   = mosi_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_nbytes_o = out_nb_q;
    assign out_last_o   = out_last_q;

endmodule

// File: tb/tb_xldr_spi_flash_fetch.sv
// ----------------------------------------------------------------------------
// tb_xldr_spi_flash_fetch
//
// Three fetch engines (SCLK half-period 1, 2 and 4) share one SPI flash model
// whose byte i reads back as i[7:0]. One engine is selected at a time; the
// others see no start/abort and stay idle. Received words are logged by a
// monitor and compared against words built directly from the fetch window.
// ----------------------------------------------------------------------------
module tb_xldr_spi_flash_fetch;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst_n;
    logic        start, abort, out_ready, miso;
    logic [23:0] base_addr, length;
    logic [1:0]  sel;

    logic        start_a [0:2];
    logic        abort_a [0:2];
    logic        busy_a  [0:2];
    logic        done_a  [0:2];
    logic        sclk_a  [0:2];
    logic        ncs_a   [0:2];
    logic        mosi_a  [0:2];
    logic        valid_a [0:2];
    logic        last_a  [0:2];
    logic [31:0] data_a  [0:2];
    logic [1:0]  nb_a    [0:2];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        assign start_a[g] = start && (sel == 2'(g));
        assign abort_a[g] = abort && (sel == 2'(g));
        xldr_spi_flash_fetch #(
            .g_clk_div  (DIV),
            .g_read_cmd (8'h03)
        ) u_dut (
            .clk_sys_i    (clk_sys),
            .rst_n_i      (rst_n),
            .start_i      (start_a[g]),
            .abort_i      (abort_a[g]),
            .base_addr_i  (base_addr),
            .length_i     (length),
            .busy_o       (busy_a[g]),
            .done_o       (done_a[g]),
            .spi_sclk_o   (sclk_a[g]),
            .spi_ncs_o    (ncs_a[g]),
            .spi_mosi_o   (mosi_a[g]),
            .spi_miso_i   (miso),
            .out_valid_o  (valid_a[g]),
            .out_ready_i  (out_ready),
            .out_data_o   (data_a[g]),
            .out_nbytes_o (nb_a[g]),
            .out_last_o   (last_a[g])
        );
    end

    logic        busy, done, sclk, ncs, mosi, valid, last;
    logic [31:0] data;
    logic [1:0]  nb;
    assign busy  = busy_a[sel];
    assign done  = done_a[sel];
    assign sclk  = sclk_a[sel];
    assign ncs   = ncs_a[sel];
    assign mosi  = mosi_a[sel];
    assign valid = valid_a[sel];
    assign last  = last_a[sel];
    assign data  = data_a[sel];
    assign nb    = nb_a[sel];

    function automatic int div_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    // ---------------- SPI flash model: byte[i] = i[7:0] ----------------
    int          rise_cnt = 0;
    logic [31:0] cmd_cap  = 32'd0;

    always @(posedge sclk or posedge ncs) begin
        if (ncs) begin
            rise_cnt <= 0;
        end else begin
            if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], mosi};
            rise_cnt <= rise_cnt + 1;
        end
    end

    int          m_idx;
    logic [7:0]  m_byte;
    always @(negedge sclk) begin
        if (!ncs && rise_cnt >= 32) begin
            m_idx  = rise_cnt - 32;
            m_byte = 8'(cmd_cap[23:0] + 24'(m_idx / 8));
            miso  <= m_byte[3'(7 - (m_idx % 8))];
        end
    end

    // ---------------- monitor (samples on falling clk edge) ----------------
    int          cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    logic [31:0] got_data [0:1023];
    logic [1:0]  got_nb   [0:1023];
    logic        got_last [0:1023];
    int          got_n = 0;
    int          done_hi = 0, ncs_low = 0, valid_hi = 0, stab_viol = 0;
    int          ncs_fall_cyc = 0, n_rise = 0, first_rise_cyc = 0;
    int          first_rise_dly = 0, period0 = 0;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_hold = 1'b0;
    logic [34:0] prev_word = 35'd0;

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (valid && out_ready && got_n < 1024) begin
                got_data[got_n] = data;
                got_nb[got_n]   = nb;
                got_last[got_n] = last;
                got_n           = got_n + 1;
            end
            if (prev_hold && valid && ({data, nb, last} != prev_word)) stab_viol++;
            prev_hold = valid && !out_ready;
            prev_word = {data, nb, last};
            if (done)   done_hi++;
            if (!ncs)   ncs_low++;
            if (valid)  valid_hi++;
            if (prev_ncs && !ncs) begin
                ncs_fall_cyc = cyc;
                n_rise       = 0;
            end
            if (!ncs && !prev_sclk && sclk) begin
                if (n_rise == 0) begin
                    first_rise_cyc = cyc;
                    first_rise_dly = cyc - ncs_fall_cyc;
                end else if (n_rise == 1) begin
                    period0 = cyc - first_rise_cyc;
                end
                n_rise++;
            end
            prev_ncs  = ncs;
            prev_sclk = sclk;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [23:0] addr, input int len, input int i);
        logic [31:0] w;
        int          k;
        w = 32'd0;
        for (int b = 0; b < 4; b++) begin
            k = 4 * i + b;
            if (k < len) w[31 - 8 * b -: 8] = 8'(int'(addr) + k);
        end
        return w;
    endfunction

    task automatic tick_clk();
        @(posedge clk_sys);
        #1;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 200 cycles after first valid
    task automatic do_fetch(input logic [1:0] s, input logic [23:0] addr, input int len,
                            input int mode, input bit poke);
        int base_n, base_done, nw, cnt, hold, rc0;
        bit seen_valid;
        sel = s;
        base_n = got_n;
        base_done = done_hi;
        hold = 0;
        rc0 = 0;
        seen_valid = 0;
        cnt = 0;
        tick_clk();
        base_addr = addr;
        length    = 24'(len);
        start     = 1'b1;
        tick_clk();
        start = 1'b0;
        while (!done && cnt < 20000) begin
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (valid) seen_valid = 1;
                if (seen_valid && hold < 200) begin
                    out_ready = 1'b0;
                    hold++;
                    if (hold == 150) rc0 = rise_cnt;
                    if (hold == 199) begin
                        check_val("stall_sclk_frozen", 64'(rise_cnt), 64'(rc0));
                        check_val("stall_sclk_low", 64'(sclk), 64'd0);
                        check_val("stall_ncs_low", 64'(ncs), 64'd0);
                    end
                end else begin
                    out_ready = 1'b1;
                end
            end
            if (poke && cnt == 40) begin
                start     = 1'b1;
                base_addr = addr + 24'h55;
                length    = 24'd3;
            end else if (poke && cnt == 41) begin
                start = 1'b0;
            end
            tick_clk();
            cnt++;
        end
        check_val("done_seen", 64'(done), 64'd1);
        check_val("ncs_at_done", 64'(ncs), 64'd1);
        check_val("busy_at_done", 64'(busy), 64'd0);
        tick_clk();
        check_val("done_width", 64'(done_hi - base_done), 64'd1);
        check_val("cmd_word", 64'(cmd_cap), 64'({8'h03, addr}));
        check_val("sclk_first_rise", 64'(first_rise_dly), 64'(div_of(s)));
        check_val("sclk_period", 64'(period0), 64'(2 * div_of(s)));
        nw = (len + 3) / 4;
        check_val("word_count", 64'(got_n - base_n), 64'(nw));
        for (int i = 0; i < nw && (base_n + i) < got_n; i++) begin
            check_val("word_data", 64'(got_data[base_n + i]), 64'(exp_word(addr, len, i)));
            check_val("word_nbytes", 64'(got_nb[base_n + i]),
                      64'((i == nw - 1) ? ((len - 1) % 4) : 3));
            check_val("word_last", 64'(got_last[base_n + i]), 64'(i == nw - 1));
        end
        out_ready = 1'b1;
    endtask

    task automatic zero_len(input logic [1:0] s);
        int base_ncs, base_valid;
        sel = s;
        tick_clk();
        base_ncs   = ncs_low;
        base_valid = valid_hi;
        base_addr  = 24'h123456;
        length     = 24'd0;
        start      = 1'b1;
        tick_clk();
        start = 1'b0;
        check_val("zero_done", 64'(done), 64'd1);
        check_val("zero_busy", 64'(busy), 64'd0);
        tick_clk();
        check_val("zero_done_width", 64'(done), 64'd0);
        repeat (10) tick_clk();
        check_val("zero_ncs_activity", 64'(ncs_low - base_ncs), 64'd0);
        check_val("zero_valid_activity", 64'(valid_hi - base_valid), 64'd0);
    endtask

    task automatic abort_fetch(input logic [1:0] s, input logic [23:0] addr);
        int base_n, base_done, cnt;
        sel = s;
        base_n = got_n;
        base_done = done_hi;
        cnt = 0;
        tick_clk();
        base_addr = addr;
        length    = 24'd64;
        start     = 1'b1;
        tick_clk();
        start = 1'b0;
        while (rise_cnt < 32 + 9 * 8 && cnt < 5000) begin
            out_ready = ($urandom_range(0, 1) != 0);
            tick_clk();
            cnt++;
        end
        check_val("abort_reached_byte10", 64'(rise_cnt >= 32 + 9 * 8), 64'd1);
        abort = 1'b1;
        tick_clk();
        abort = 1'b0;
        check_val("abort_ncs", 64'(ncs), 64'd1);
        check_val("abort_valid", 64'(valid), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_sclk", 64'(sclk), 64'd0);
        repeat (40) tick_clk();
        check_val("abort_no_done", 64'(done_hi - base_done), 64'd0);
        check_val("abort_word_bound", 64'((got_n - base_n) <= 3), 64'd1);
        for (int i = 0; i < got_n - base_n; i++) begin
            check_val("abort_prefix_word", 64'(got_data[base_n + i]), 64'(exp_word(addr, 64, i)));
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        base_addr = 24'd0;
        length    = 24'd0;
        sel       = 2'd1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_val("rst_ncs", 64'(ncs), 64'd1);
        check_val("rst_sclk", 64'(sclk), 64'd0);
        check_val("rst_mosi", 64'(mosi), 64'd0);
        check_val("rst_valid", 64'(valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick_clk();

        do_fetch(2'd1, 24'h000000, 8, 0, 0);
        check_val("lit_word0", 64'(got_data[got_n - 2]), 64'h00010203);
        check_val("lit_word1", 64'(got_data[got_n - 1]), 64'h04050607);
        do_fetch(2'd1, 24'h000010, 5, 0, 0);
        check_val("lit_partial", 64'(got_data[got_n - 1]), 64'h14000000);
        do_fetch(2'd1, 24'h000020, 12, 2, 0);
        zero_len(2'd1);
        abort_fetch(2'd1, 24'h000100);
        do_fetch(2'd1, 24'h000040, 9, 1, 0);
        do_fetch(2'd1, 24'($urandom), int'($urandom_range(1, 20)), 1, 1);
        do_fetch(2'd0, 24'($urandom), int'($urandom_range(1, 16)), 1, 0);
        do_fetch(2'd0, 24'hFFFFFA, 11, 0, 0);
        do_fetch(2'd2, 24'($urandom), int'($urandom_range(1, 16)), 1, 0);
        do_fetch(2'd2, 24'h000003, 4, 0, 1);
        zero_len(2'd2);

        // asynchronous reset in the middle of a fetch
        sel = 2'd1;
        tick_clk();
        base_addr = 24'h000200;
        length    = 24'd16;
        start     = 1'b1;
        tick_clk();
        start = 1'b0;
        repeat (100) tick_clk();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_ncs", 64'(ncs), 64'd1);
        check_val("arst_sclk", 64'(sclk), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_valid", 64'(valid), 64'd0);
        tick_clk();
        rst_n = 1'b1;
        tick_clk();
        do_fetch(2'd1, 24'h000300, 7, 1, 0);

        check_val("output_stable_while_stalled", 64'(stab_viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
